// File: rtl/usb_pkg.sv
// usb_pkg: shared definitions for the USB handshake/token datapath.
//   - supported PID nibbles (ACK, NAK, DATA)
//   - SYNC_PATTERN, transmitted bit0 first (seven 0s, then a 1)
//   - pid_state_t: state encoding for the pid_sender FSM
//   - is_supported_pid(): PID acceptance filter
//   - pid_byte(): builds the on-wire byte {~pid, pid}
package usb_pkg;

    localparam logic [3:0] ACK_PID      = 4'b0010;
    localparam logic [3:0] NAK_PID      = 4'b1010;
    localparam logic [3:0] DATA_PID     = 4'b0011;
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DONE
    } pid_state_t;

    function automatic logic is_supported_pid(input logic [3:0] pid);
        return (pid == ACK_PID) || (pid == NAK_PID) || (pid == DATA_PID);
    endfunction

    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: 8-bit parallel-load shift register, LSB first.
// Each bit is held BIT_CYCLES clocks, timed by a prescaler; a 3-bit bit
// counter advances on prescaler wrap.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - load load_data, restart prescaler and bit counter
//   load_data  - byte to serialize
//   shift      - advance timing (high while a field is on the wire)
//   ser_bit    - current serial bit (register output)
//   last_bit   - final clock of bit 7 of the current byte
module bit_serializer #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    output logic       ser_bit,
    output logic       last_bit
);

    localparam logic [3:0] PRE_MAX = 4'(BIT_CYCLES - 1);

    logic [7:0] sreg;
    logic [3:0] pre;
    logic [2:0] bit_cnt;
    logic       pre_wrap;

    assign pre_wrap = (pre == PRE_MAX);
    assign last_bit = shift && pre_wrap && (bit_cnt == 3'd7);
    assign ser_bit  = sreg[0];

    // Zeros shift in behind the data, so the line returns to 0 once
    // the last bit has been clocked out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            pre     <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sreg    <= load_data;
            pre     <= '0;
            bit_cnt <= '0;
        end else if (shift) begin
            if (pre_wrap) begin
                pre     <= '0;
                sreg    <= {1'b0, sreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end else begin
                pre <= pre + 4'd1;
            end
        end
    end

endmodule

// File: rtl/pid_sender.sv
// pid_sender: serializes a 4-bit USB PID as {~pid, pid}, LSB first,
// onto a raw serial line ahead of the NRZI/bit-stuff stage.
// Build option: PID_SYNC_EN - when defined, the SYNC pattern is sent
// before the PID field (16-bit frame); otherwise 8-bit frame.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   start_send  - send request, sampled only in IDLE
//   pid_in      - PID nibble to send
//   s_out       - serial data bit
//   s_out_en    - high while s_out carries a valid bit
//   busy        - transmission in progress
//   PID_sent    - one-cycle pulse after the last bit
//   pid_error   - one-cycle pulse on request with unsupported PID
module pid_sender
    import usb_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_send,
    input  logic [3:0] pid_in,
    output logic       s_out,
    output logic       s_out_en,
    output logic       busy,
    output logic       PID_sent,
    output logic       pid_error
);

    pid_state_t state;
    logic [3:0] pid_q;
    logic       accept;
    logic       ser_load;
    logic [7:0] ser_data;
    logic       ser_last;

    assign accept = (state == ST_IDLE) && start_send && is_supported_pid(pid_in);

    // The serializer is loaded on acceptance (first field) and on the
    // last clock of SYNC (PID byte), so fields run back to back.
    always_comb begin
        ser_load = 1'b0;
        ser_data = '0;
        if (accept) begin
            ser_load = 1'b1;
`ifdef PID_SYNC_EN
            ser_data = SYNC_PATTERN;
`else
            ser_data = pid_byte(pid_in);
`endif
        end else if (state == ST_SYNC && ser_last) begin
            ser_load = 1'b1;
            ser_data = pid_byte(pid_q);
        end
    end

    bit_serializer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .load_data (ser_data),
        .shift     (s_out_en),
        .ser_bit   (s_out),
        .last_bit  (ser_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pid_q     <= '0;
            s_out_en  <= 1'b0;
            busy      <= 1'b0;
            PID_sent  <= 1'b0;
            pid_error <= 1'b0;
        end else begin
            PID_sent  <= 1'b0;
            pid_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        pid_q    <= pid_in;
                        busy     <= 1'b1;
                        s_out_en <= 1'b1;
`ifdef PID_SYNC_EN
                        state    <= ST_SYNC;
`else
                        state    <= ST_PID;
`endif
                    end else if (start_send) begin
                        pid_error <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (ser_last) begin
                        state <= ST_PID;
                    end
                end
                ST_PID: begin
                    if (ser_last) begin
                        s_out_en <= 1'b0;
                        PID_sent <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_sender.sv
// tb_pid_sender: self-checking bench for pid_sender.
// Two instances: BIT_CYCLES=1 (dut_a) and BIT_CYCLES=3 (dut_b).
// Expected serial bits are queued when a request is driven and popped
// by per-instance monitors whenever s_out_en is high.
module tb_pid_sender;

`ifdef PID_SYNC_EN
    localparam int unsigned FRAME = 16;
`else
    localparam int unsigned FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a, start_b;
    logic [3:0] pid_a, pid_b;
    logic       so_a, en_a, busy_a, sent_a, err_a;
    logic       so_b, en_b, busy_b, sent_b, err_b;

    int checks   = 0;
    int failures = 0;

    logic q_a[$];
    logic q_b[$];

    typedef struct {
        logic [3:0] pid;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    pid_sender #(.BIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .start_send(start_a), .pid_in(pid_a),
        .s_out(so_a), .s_out_en(en_a), .busy(busy_a),
        .PID_sent(sent_a), .pid_error(err_a)
    );

    pid_sender #(.BIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .start_send(start_b), .pid_in(pid_b),
        .s_out(so_b), .s_out_en(en_b), .busy(busy_b),
        .PID_sent(sent_b), .pid_error(err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame bit i as it should appear on the wire.
    function automatic logic exp_bit(input logic [3:0] pid, input int unsigned idx);
        int unsigned i;
        i = idx;
`ifdef PID_SYNC_EN
        if (i < 8) return (i == 7);
        i = i - 8;
`endif
        if (i < 4) return pid[i];
        return ~pid[i - 4];
    endfunction

    always @(negedge clk) begin
        if (!rst && en_a) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_bit: got s_out_en=1 expected 0 at t=%0t", $time);
            end else begin
                chk("a_s_out", so_a, q_a.pop_front());
            end
        end
        if (!rst && en_b) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_bit: got s_out_en=1 expected 0 at t=%0t", $time);
            end else begin
                chk("b_s_out", so_b, q_b.pop_front());
            end
        end
    end

    task automatic run_a(input logic [3:0] pid, input logic exp_err);
        int unsigned cyc;
        pid_a   = pid;
        start_a = 1'b1;
        if (!exp_err)
            for (int unsigned i = 0; i < FRAME; i++) q_a.push_back(exp_bit(pid, i));
        @(negedge clk);
        start_a = 1'b0;
        pid_a   = ~pid;
        chk("a_pid_error", err_a, exp_err);
        chk("a_busy_t1", busy_a, !exp_err);
        if (exp_err) begin
            chk("a_en_on_reject", en_a, 1'b0);
            @(negedge clk);
            chk("a_pid_error_pulse", err_a, 1'b0);
            chk("a_busy_reject", busy_a, 1'b0);
            return;
        end
        cyc = 1;
        while (!sent_a && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("a_sent_latency", cyc, FRAME + 1);
        chk("a_done_en", en_a, 1'b0);
        chk("a_done_s_out", so_a, 1'b0);
        chk("a_done_busy", busy_a, 1'b1);
        start_a = 1'b1;
        pid_a   = 4'b0010;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_idle_busy", busy_a, 1'b0);
        chk("a_sent_pulse", sent_a, 1'b0);
        chk("a_queue_drained", q_a.size(), 0);
        @(negedge clk);
        chk("a_done_start_ignored", en_a, 1'b0);
    endtask

    initial begin
        int unsigned cyc;
        int unsigned en_cnt;
        int unsigned sent_cnt;

        vecs[0] = '{4'b0010, 1'b0};
        vecs[1] = '{4'b1010, 1'b0};
        vecs[2] = '{4'b0011, 1'b0};
        vecs[3] = '{4'b1111, 1'b1};
        vecs[4] = '{4'b0000, 1'b1};
        vecs[5] = '{4'b1011, 1'b1};

        start_a = 1'b0; pid_a = '0;
        start_b = 1'b0; pid_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_s_out", {so_a, so_b}, 2'b00);
        chk("rst_en", {en_a, en_b}, 2'b00);
        chk("rst_busy", {busy_a, busy_b}, 2'b00);
        chk("rst_sent", {sent_a, sent_b}, 2'b00);
        chk("rst_err", {err_a, err_b}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        for (int unsigned v = 0; v < 6; v++) begin
            run_a(vecs[v].pid, vecs[v].exp_err);
        end

        // NAK with BIT_CYCLES=3; request and pid changes mid-frame.
        pid_b   = 4'b1010;
        start_b = 1'b1;
        for (int unsigned i = 0; i < FRAME; i++)
            repeat (3) q_b.push_back(exp_bit(4'b1010, i));
        @(negedge clk);
        start_b = 1'b0;
        chk("b_busy_t1", busy_b, 1'b1);
        cyc = 1;
        en_cnt = 0;
        while (!sent_b && cyc < 400) begin
            if (en_b) en_cnt++;
            if (cyc == 5) begin start_b = 1'b1; pid_b = 4'b0010; end
            if (cyc == 9) begin start_b = 1'b0; pid_b = 4'b1111; end
            if (cyc == 13) begin start_b = 1'b1; pid_b = 4'b0011; end
            if (cyc == 16) start_b = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("b_en_cycles", en_cnt, FRAME * 3);
        chk("b_sent_latency", cyc, FRAME * 3 + 1);
        chk("b_done_en", en_b, 1'b0);
        chk("b_no_error_midframe", err_b, 1'b0);
        @(negedge clk);
        chk("b_idle_busy", busy_b, 1'b0);
        chk("b_queue_drained", q_b.size(), 0);

        // Reset during bit 4 of the PID field.
        pid_a   = 4'b0010;
        start_a = 1'b1;
        for (int unsigned i = 0; i < FRAME; i++) q_a.push_back(exp_bit(4'b0010, i));
        @(negedge clk);
        start_a = 1'b0;
        repeat (FRAME - 8 + 4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_s_out", so_a, 1'b0);
        chk("midrst_en", en_a, 1'b0);
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_sent", sent_a, 1'b0);
        chk("midrst_err", err_a, 1'b0);
        q_a.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sent_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (sent_a) sent_cnt++;
        end
        chk("midrst_no_sent", sent_cnt, 0);
        run_a(4'b0010, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
